mem_cmd_arbiter: RTL and testbench
==================================

Name: mem_cmd_arbiter

Overview:
- Shares the single MIG user-interface command/write-data port between the camera frame writer (write requester) and host_if readout (read requester).
- Sits in the DDR clock domain between the requesters and the MIG.
- Grants round-robin with a per-requester burst limit and a write-urgency override. Tracks outstanding reads to bound MIG read-return occupancy.

Parameters:
- ADDR_W, 29, MIG app_addr width.
- DATA_W, 128, MIG UI data width.
- MAX_BURST, 4, maximum consecutive commands granted to one requester while the other is waiting.
- MAX_RD_OUTSTANDING, 64, maximum issued-but-unreturned reads.

Ports:
- clk in 1: DDR UI clock.
- reset_clk in 1: synchronous, active-high reset.
- wr_req in 1: write command request; held until wr_ack.
- wr_addr in ADDR_W: write address.
- wr_data in DATA_W: write data.
- wr_urgent in 1: writer FIFO near full; forces write priority.
- wr_ack out 1: write command and data both accepted this cycle.
- rd_req in 1: read request; held until rd_ack.
- rd_addr in ADDR_W: read address.
- rd_ack out 1: read command accepted this cycle.
- rd_data out DATA_W: pass-through of app_rd_data.
- rd_data_valid out 1: pass-through of app_rd_data_valid.
- app_en out 1, app_cmd out 3, app_addr out ADDR_W, app_rdy in 1: MIG command port.
- app_wdf_wren out 1, app_wdf_end out 1, app_wdf_data out DATA_W, app_wdf_rdy in 1: MIG write-data port.
- app_rd_data in DATA_W, app_rd_data_valid in 1: MIG read return.
- rd_outstanding out 7: current outstanding read count.

Behaviour:
- Reset: app_en, app_wdf_wren, app_wdf_end, wr_ack, rd_ack = 0. app_cmd = CMD_READ. app_addr, app_wdf_data = 0. rd_outstanding = 0. burst_cnt = 0. last_grant = READ. State = S_ARB. Reset mid-command abandons the command with no ack.
- States:
  - S_ARB: one arbitration cycle, no command driven.
  - S_WR: write command issue.
  - S_RD: read command issue.
- S_ARB, priority order:
  1. wr_urgent & wr_req → S_WR.
  2. Only one requester eligible → that one.
  3. Both eligible → the requester other than last_grant if burst_cnt == MAX_BURST, otherwise last_grant.
  - Read eligibility requires rd_req & rd_outstanding < MAX_RD_OUTSTANDING.
  - On grant change, burst_cnt is cleared; on each ack, burst_cnt increments, saturating at MAX_BURST.
- Entering S_WR/S_RD registers the address (and data) from the requester; outputs are registered.
- S_WR:
  - app_en = 1, app_cmd = CMD_WRITE until app_rdy is seen; app_wdf_wren = app_wdf_end = 1 until app_wdf_rdy is seen.
  - cmd_done and data_done flags latch each acceptance independently; they may occur in either order or in the same cycle.
  - wr_ack is combinational: asserted in the cycle the second of the two acceptances occurs. Next state S_ARB.
- S_RD:
  - app_en = 1, app_cmd = CMD_READ.
  - rd_ack is combinational = app_rdy in this state. Next state S_ARB.
- One-cycle S_ARB gap after every ack lets requesters update req. Peak rate is 1 command per 2 clocks.
- rd_outstanding:
  - +1 on rd_ack, −1 on app_rd_data_valid; simultaneous events leave it unchanged.
  - Never exceeds MAX_RD_OUTSTANDING. Underflow cannot occur by construction; the bench flags it.
- rd_data/rd_data_valid are combinational pass-through with no latency.
- Requests deasserted before ack are a protocol violation; the granted command completes anyway.

Decomposition:
- Shared package mem_arb_pkg holds:
  - CMD_WRITE = 3'b000 and CMD_READ = 3'b001.
  - State encoding S_ARB/S_WR/S_RD.
  - Grant encoding GRANT_WR/GRANT_RD.
- Single module; no sub-module is warranted.

Test Plan:
- Reads only, rd_req held, app_rdy = 1, rd_addr stepping by 8 from 0x100 → app_en pulses every 2nd cycle with app_cmd = 001 and addresses 0x100, 0x108, …; rd_ack coincides with app_en & app_rdy.
- Both requesting continuously, MAX_BURST = 4, no urgency → sequence of 4 writes, 4 reads, 4 writes; wr_ack count equals app_wdf_wren acceptance count.
- In S_WR, app_rdy = 1 at cycle 1 and app_wdf_rdy = 0 until cycle 5 → app_en drops after cycle 1; wr_ack is asserted only at cycle 5; exactly one command and one data beat are issued.
- MAX_RD_OUTSTANDING = 8, no read return → exactly 8 rd_acks then stall with rd_outstanding = 8. One app_rd_data_valid → rd_outstanding = 7 and the next read issues. Simultaneous ack + valid keeps the count.
- Reads in progress with burst_cnt = 1, then wr_urgent & wr_req asserted → next S_ARB grants write regardless of burst_cnt.
- reset_clk pulsed mid-S_WR with app_wdf_rdy = 0 → next cycle all outputs at reset values, no wr_ack, rd_outstanding = 0; arbitration resumes normally after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the MIG command-port arbiter.
// Command codes match the MIG app_cmd field.
package mem_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    S_ARB,
    S_WR,
    S_RD
  } state_t;

  typedef enum logic {
    GRANT_WR,
    GRANT_RD
  } grant_t;

endpackage

// File: rtl/mem_cmd_arbiter.sv
// Shares the MIG UI command/write-data port between the frame writer
// and host readout: round-robin, burst-limited, write-urgency override.
module mem_cmd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W             = 29,
  parameter int DATA_W             = 128,
  parameter int MAX_BURST          = 4,
  parameter int MAX_RD_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset_clk,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_urgent,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [6:0]        rd_outstanding
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [6:0] RD_MAX = 7'(MAX_RD_OUTSTANDING);

  state_t        state;
  grant_t        last_grant;
  grant_t        grant;
  grant_t        other;
  logic          grant_v;
  logic [BW-1:0] burst_cnt;
  logic          cmd_done;
  logic          data_done;

  logic wr_elig;
  logic rd_elig;
  logic urg;
  logic both;
  logic only_wr;
  logic only_rd;
  logic burst_full;
  logic cmd_acc;
  logic dat_acc;

  assign rd_data       = app_rd_data;
  assign rd_data_valid = app_rd_data_valid;

  assign cmd_acc = app_en & app_rdy;
  assign dat_acc = app_wdf_wren & app_wdf_rdy;

  assign wr_ack = (state == S_WR)
                & (cmd_done | cmd_acc)
                & (data_done | dat_acc);
  assign rd_ack = (state == S_RD) & app_rdy;

  assign wr_elig    = wr_req;
  assign rd_elig    = rd_req & (rd_outstanding < RD_MAX);
  assign urg        = wr_urgent & wr_req;
  assign both       = ~urg & wr_elig & rd_elig;
  assign only_wr    = ~urg & wr_elig & ~rd_elig;
  assign only_rd    = ~wr_elig & rd_elig;
  assign burst_full = (burst_cnt == BURST_MAX);
  assign other      = (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;

  always_comb begin
    grant_v = 1'b0;
    grant   = last_grant;
    unique case (1'b1)
      urg: begin
        grant_v = 1'b1;
        grant   = GRANT_WR;
      end
      both: begin
        grant_v = 1'b1;
        grant   = burst_full ? other : last_grant;
      end
      only_wr: begin
        grant_v = 1'b1;
        grant   = GRANT_WR;
      end
      only_rd: begin
        grant_v = 1'b1;
        grant   = GRANT_RD;
      end
      default: begin
        grant_v = 1'b0;
        grant   = last_grant;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state          <= S_ARB;
      last_grant     <= GRANT_RD;
      burst_cnt      <= '0;
      cmd_done       <= 1'b0;
      data_done      <= 1'b0;
      app_en         <= 1'b0;
      app_cmd        <= CMD_READ;
      app_addr       <= '0;
      app_wdf_wren   <= 1'b0;
      app_wdf_end    <= 1'b0;
      app_wdf_data   <= '0;
      rd_outstanding <= '0;
    end else begin
      unique case ({rd_ack, app_rd_data_valid})
        2'b10:   rd_outstanding <= rd_outstanding + 7'd1;
        2'b01:   rd_outstanding <= rd_outstanding - 7'd1;
        default: rd_outstanding <= rd_outstanding;
      endcase

      unique case (state)
        S_ARB: begin
          if (grant_v) begin
            last_grant <= grant;
            if (grant != last_grant)
              burst_cnt <= '0;
            app_en    <= 1'b1;
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
            if (grant == GRANT_WR) begin
              state        <= S_WR;
              app_cmd      <= CMD_WRITE;
              app_addr     <= wr_addr;
              app_wdf_data <= wr_data;
              app_wdf_wren <= 1'b1;
              app_wdf_end  <= 1'b1;
            end else begin
              state    <= S_RD;
              app_cmd  <= CMD_READ;
              app_addr <= rd_addr;
            end
          end
        end
        S_WR: begin
          // command and data beat may be accepted in either order
          if (cmd_acc) begin
            app_en   <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (dat_acc) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            data_done    <= 1'b1;
          end
          if (wr_ack) begin
            state <= S_ARB;
            if (!burst_full)
              burst_cnt <= burst_cnt + 1'b1;
          end
        end
        S_RD: begin
          if (rd_ack) begin
            app_en <= 1'b0;
            state  <= S_ARB;
            if (!burst_full)
              burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter: vector table for the read stream,
// hand-written sequences for burst, handshake, credit and reset cases.
module tb_mem_cmd_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 29;
  localparam int DW  = 128;
  localparam int MB  = 4;
  localparam int MRO = 8;

  logic          clk = 1'b0;
  logic          reset_clk;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_urgent;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic [6:0]    rd_outstanding;

  int tests = 0;
  int fails = 0;

  mem_cmd_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_BURST(MB),
    .MAX_RD_OUTSTANDING(MRO)
  ) dut (
    .clk(clk),
    .reset_clk(reset_clk),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_urgent(wr_urgent),
    .wr_ack(wr_ack),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .rd_outstanding(rd_outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset_clk === 1'b0) begin
      tests++;
      if (rd_outstanding > 7'(MRO)) begin
        fails++;
        $display("FAIL outstanding_bound: got %0d limit %0d",
                 rd_outstanding, MRO);
      end
    end
  end

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_clk         = 1'b1;
    wr_req            = 1'b0;
    wr_addr           = '0;
    wr_data           = '0;
    wr_urgent         = 1'b0;
    rd_req            = 1'b0;
    rd_addr           = '0;
    app_rdy           = 1'b0;
    app_wdf_rdy       = 1'b0;
    app_rd_data       = '0;
    app_rd_data_valid = 1'b0;
    tick();
    tick();
    reset_clk = 1'b0;
  endtask

  // waits for rd_ack at a negedge; leaves time at that negedge
  task automatic wait_rd_ack(input int budget, output bit found);
    found = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rd_ack) begin
        found = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_app_en(input int budget, output bit found);
    found = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (app_en) begin
        found = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic urg_case(input logic urg,
                          input logic [2:0] exp_cmd,
                          input string name);
    bit found;
    do_reset();
    rd_req      = 1'b1;
    rd_addr     = 29'h40;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    wait_rd_ack(8, found);
    check({name, ".first_rd"}, found, 1'b1);
    wr_req    = 1'b1;
    wr_urgent = urg;
    wr_addr   = 29'h80;
    tick();
    tick();
    wait_app_en(4, found);
    check({name, ".issued"}, found, 1'b1);
    check({name, ".cmd"}, app_cmd, exp_cmd);
    check({name, ".wren"}, app_wdf_wren, exp_cmd == CMD_WRITE);
    tick();
  endtask

  typedef struct {
    logic          rq;
    logic [AW-1:0] ra;
    logic          rdy;
    logic          vld;
    logic [DW-1:0] rdat;
    logic          en;
    logic [AW-1:0] addr;
    logic          ack;
    logic [6:0]    outst;
  } vec_t;

  vec_t vt[12];

  initial begin
    bit    found;
    int    nacks;
    int    wacks;
    int    wacc;
    int    cmd_n;
    int    dat_n;
    bit    data_ok;
    string seq;

    vt[0]  = '{1, 29'h100, 1, 0, 128'h0,    0, 29'h0,   0, 7'd0};
    vt[1]  = '{1, 29'h100, 1, 0, 128'h0,    1, 29'h100, 1, 7'd0};
    vt[2]  = '{1, 29'h108, 1, 0, 128'h0,    0, 29'h0,   0, 7'd1};
    vt[3]  = '{1, 29'h108, 1, 0, 128'h0,    1, 29'h108, 1, 7'd1};
    vt[4]  = '{1, 29'h110, 1, 0, 128'h0,    0, 29'h0,   0, 7'd2};
    vt[5]  = '{1, 29'h110, 1, 1, 128'hDEAD, 1, 29'h110, 1, 7'd2};
    vt[6]  = '{1, 29'h118, 0, 0, 128'h0,    0, 29'h0,   0, 7'd2};
    vt[7]  = '{1, 29'h118, 0, 0, 128'h0,    1, 29'h118, 0, 7'd2};
    vt[8]  = '{1, 29'h118, 1, 0, 128'h0,    1, 29'h118, 1, 7'd2};
    vt[9]  = '{0, 29'h120, 1, 1, 128'hCAFE, 0, 29'h0,   0, 7'd3};
    vt[10] = '{0, 29'h120, 1, 0, 128'h0,    0, 29'h0,   0, 7'd2};
    vt[11] = '{0, 29'h120, 1, 0, 128'h0,    0, 29'h0,   0, 7'd2};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      rd_req            = vt[i].rq;
      rd_addr           = vt[i].ra;
      app_rdy           = vt[i].rdy;
      app_rd_data_valid = vt[i].vld;
      app_rd_data       = vt[i].rdat;
      @(negedge clk);
      check($sformatf("vec%0d.en", i), app_en, vt[i].en);
      check($sformatf("vec%0d.ack", i), rd_ack, vt[i].ack);
      check($sformatf("vec%0d.outst", i), rd_outstanding, vt[i].outst);
      check($sformatf("vec%0d.pass", i),
            {rd_data_valid, rd_data}, {vt[i].vld, vt[i].rdat});
      check($sformatf("vec%0d.nowr", i), {wr_ack, app_wdf_wren}, 2'b00);
      if (vt[i].en) begin
        check($sformatf("vec%0d.cmd", i), app_cmd, CMD_READ);
        check($sformatf("vec%0d.addr", i), app_addr, vt[i].addr);
      end
      tick();
    end

    // round robin with burst limit: one write alone, then both requesting
    do_reset();
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    wr_req      = 1'b1;
    wr_addr     = 29'h1000;
    wr_data     = 128'h5000;
    nacks = 0; wacks = 0; wacc = 0; data_ok = 1; seq = "";
    for (int c = 0; c < 80 && nacks < 12; c++) begin
      @(negedge clk);
      if (app_en) rd_req = 1'b1;
      if (app_wdf_wren && app_wdf_rdy) wacc++;
      if (wr_ack) begin
        seq = {seq, "W"};
        if (app_wdf_data !== wr_data || app_addr !== wr_addr) data_ok = 0;
        wr_data = wr_data + 1;
        wr_addr = wr_addr + 8;
        wacks++;
        nacks++;
      end
      if (rd_ack) begin
        seq = {seq, "R"};
        nacks++;
      end
      tick();
    end
    tests++;
    if (seq != "WWWWRRRRWWWW") begin
      fails++;
      $display("FAIL burst.seq: got %s expected WWWWRRRRWWWW", seq);
    end
    check("burst.wacks", wacks, 8);
    check("burst.wacc", wacc, 8);
    check("burst.wdata", data_ok, 1'b1);
    wr_req = 1'b0;
    rd_req = 1'b0;

    // command accepted first, data beat held off until cycle 5
    do_reset();
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b0;
    wr_req      = 1'b1;
    wr_addr     = 29'h2000;
    wr_data     = 128'hABC;
    cmd_n = 0; dat_n = 0;
    wait_app_en(6, found);
    check("split.found", found, 1'b1);
    check("split.c1", {app_en, app_wdf_wren, app_wdf_end, wr_ack}, 4'b1110);
    check("split.addr", app_addr, 29'h2000);
    check("split.data", app_wdf_data, 128'hABC);
    cmd_n += int'(app_en & app_rdy);
    tick();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("split.c%0d", c),
            {app_en, app_wdf_wren, wr_ack}, 3'b010);
      cmd_n += int'(app_en & app_rdy);
      tick();
    end
    app_wdf_rdy = 1'b1;
    @(negedge clk);
    check("split.c5", {app_en, app_wdf_wren, wr_ack}, 3'b011);
    dat_n += int'(app_wdf_wren & app_wdf_rdy);
    cmd_n += int'(app_en & app_rdy);
    wr_req = 1'b0;
    tick();
    @(negedge clk);
    check("split.after", {app_en, app_wdf_wren, wr_ack}, 3'b000);
    check("split.ncmd", cmd_n, 1);
    check("split.ndat", dat_n, 1);

    // data beat accepted before the command
    do_reset();
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b1;
    wr_req      = 1'b1;
    wait_app_en(6, found);
    check("rev.c1", {found, app_wdf_wren, wr_ack}, 3'b110);
    tick();
    @(negedge clk);
    check("rev.c2", {app_en, app_wdf_wren, wr_ack}, 3'b100);
    tick();
    app_rdy = 1'b1;
    @(negedge clk);
    check("rev.c3", {app_en, wr_ack}, 2'b11);
    wr_req = 1'b0;
    tick();

    // read credit limit
    do_reset();
    rd_req  = 1'b1;
    app_rdy = 1'b1;
    nacks   = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_ack) nacks++;
      tick();
    end
    @(negedge clk);
    check("credit.acks", nacks, MRO);
    check("credit.full", rd_outstanding, 7'(MRO));
    check("credit.stall", app_en, 1'b0);
    tick();
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("credit.ret", rd_outstanding, 7'(MRO - 1));
    wait_rd_ack(6, found);
    check("credit.resume", found, 1'b1);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("credit.simul", rd_outstanding, 7'(MRO - 1));
    wait_rd_ack(6, found);
    check("credit.last", found, 1'b1);
    tick();
    @(negedge clk);
    check("credit.refull", rd_outstanding, 7'(MRO));
    nacks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (rd_ack) nacks++;
    end
    check("credit.nomore", nacks, 0);
    rd_req = 1'b0;

    // urgency override versus plain burst continuation
    urg_case(1'b0, CMD_READ, "nourg");
    urg_case(1'b1, CMD_WRITE, "urg");

    // reset in the middle of a write
    do_reset();
    rd_req  = 1'b1;
    app_rdy = 1'b1;
    wait_rd_ack(8, found);
    check("rst.rd", found, 1'b1);
    rd_req      = 1'b0;
    wr_req      = 1'b1;
    wr_addr     = 29'h3000;
    wr_data     = 128'h55;
    app_wdf_rdy = 1'b0;
    tick();
    wait_app_en(6, found);
    check("rst.wr", {found, app_cmd}, {1'b1, CMD_WRITE});
    tick();
    reset_clk = 1'b1;
    @(negedge clk);
    check("rst.noack", wr_ack, 1'b0);
    tick();
    @(negedge clk);
    check("rst.ctl", {app_en, app_wdf_wren, app_wdf_end, wr_ack, rd_ack},
          5'b00000);
    check("rst.cmd", app_cmd, CMD_READ);
    check("rst.addr", app_addr, '0);
    check("rst.wdata", app_wdf_data, '0);
    check("rst.outst", rd_outstanding, 7'd0);
    tick();
    reset_clk   = 1'b0;
    app_wdf_rdy = 1'b1;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_ack) begin
        found = 1;
        break;
      end
      tick();
    end
    check("rst.resume", found, 1'b1);
    check("rst.raddr", app_addr, 29'h3000);
    check("rst.rdata", app_wdf_data, 128'h55);
    wr_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
